// File: rtl/mem_bus_arb_pkg.sv
// Shared types for the two-requester native memory bus arbiter.
package mem_bus_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef logic [1:0] grant_t;

  localparam grant_t GRANT_NONE = 2'b00;
  localparam grant_t GRANT_M0   = 2'b01;
  localparam grant_t GRANT_M1   = 2'b10;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Combinational two-way round-robin picker; on a tie the requester other than last wins.
module mem_bus_rr_pick
  import mem_bus_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output grant_t     winner,
  output logic       any
);

  always_comb begin
    winner = GRANT_NONE;
    case (valid)
      2'b01:   winner = GRANT_M0;
      2'b10:   winner = GRANT_M1;
      2'b11:   winner = last ? GRANT_M0 : GRANT_M1;
      default: winner = GRANT_NONE;
    endcase
  end

  assign any = |valid;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native memory port between the core (m0) and a secondary master (m1).
// Optional downstream wait timeout enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        err
);

  state_t   state_q, state_d;
  grant_t   grant_q, pick;
  logic     last_q, pick_any, take, done, abort;
  mem_req_t req_q, req_m0, req_m1;

  assign req_m0 = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign req_m1 = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  mem_bus_rr_pick u_pick (
    .valid  ({m1_valid, m0_valid}),
    .last   (last_q),
    .winner (pick),
    .any    (pick_any)
  );

  assign take = (state_q == IDLE) && pick_any;
  assign done = (state_q == BUSY) && (mem_ready || abort);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (done)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once at grant so downstream sees them stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q <= GRANT_NONE;
      last_q  <= 1'b1;
      req_q   <= '0;
    end else if (take) begin
      grant_q <= pick;
      last_q  <= pick[1];
      req_q   <= pick[1] ? req_m1 : req_m0;
    end else if (done) begin
      grant_q <= GRANT_NONE;
    end
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic [15:0] wait_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                wait_q <= '0;
    else if (take)                              wait_q <= '0;
    else if ((state_q == BUSY) && !mem_ready)   wait_q <= wait_q + 16'd1;
  end

  assign abort = (state_q == BUSY) && !mem_ready && (wait_q == 16'(TIMEOUT_CYCLES));
`else
  logic [15:0] unused_timeout;

  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign abort          = 1'b0;
`endif

  always_comb begin
    mem_valid = (state_q == BUSY);
    mem_instr = req_q.instr;
    mem_addr  = req_q.addr;
    mem_wdata = req_q.wdata;
    mem_wstrb = req_q.wstrb;
    grant     = grant_q;
    m0_ready  = done && grant_q[0];
    m1_ready  = done && grant_q[1];
    m_rdata   = abort ? ERR_RDATA : mem_rdata;
    err       = abort;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one native memory port (valid/ready/instr/addr/wdata/wstrb/rdata handshake) between two requesters.
  - Requester 0: the minrv32 core.
  - Requester 1: a secondary master (debug loader or DMA).
- Round-robin grant, one outstanding transaction at a time.
- Request fields are latched at grant, so the downstream side sees stable signals until mem_ready.
- Sits between the core and the memory model or formal memory checker.

Parameters:
- TIMEOUT_CYCLES, 255: downstream wait cycles before abort. Used only with the optional feature. Must be 1..65535.
- ERR_RDATA, 32'h0000_0000: read data returned to the requester on abort.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- m0_valid / m1_valid  in  1  request from requester 0 / 1.
- m0_instr / m1_instr  in  1  request is an instruction fetch.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 means read.
- m0_ready / m1_ready  out  1  one-cycle completion pulse to that requester.
- m_rdata  out  32  read data, shared by both requesters; qualify with mN_ready.
- mem_valid  out  1  downstream request.
- mem_instr  out  1  latched instr flag.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_wstrb  out  4  latched write strobes.
- mem_ready  in  1  downstream completion.
- mem_rdata  in  32  downstream read data.
- grant  out  2  one-hot current owner; 00 when idle.
- err  out  1  one-cycle abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE. mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - grant=00, err=0, m0_ready=m1_ready=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- States: IDLE, BUSY.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one mN_valid: grant N.
  - Both valid: grant the requester not equal to last.
  - On grant, at the same edge:
    - Register instr/addr/wdata/wstrb from the winner.
    - Set mem_valid=1, grant[N]=1, last=N.
    - Go to BUSY.
  - Latency: request seen at edge k gives mem_valid=1 after edge k.
- BUSY:
  - mem_valid held at 1; latched fields stay constant. Changes on mN_* are ignored.
  - In the cycle mem_ready=1:
    - mN_ready=1 combinationally for the owner only.
    - m_rdata=mem_rdata.
    - At the next edge: mem_valid=0, grant=00, state IDLE.
- Minimum spacing: one IDLE cycle between transactions; maximum throughput is one transaction per 2 cycles plus memory wait.
- A requester that still holds valid after its ready is treated as a new request. Dropping valid is the requester's responsibility.
- mem_ready while IDLE is ignored: no mN_ready, no state change.
- Non-owner requests stay pending; they are not acknowledged and not lost.
- m_rdata=mem_rdata whenever no abort is in progress.
- Reset during BUSY: mem_valid drops immediately (asynchronous). The outstanding transaction is discarded with no ready pulse.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- When defined:
  - A 16-bit wait counter clears on grant and increments on each BUSY cycle with mem_ready=0.
  - When it equals TIMEOUT_CYCLES and mem_ready=0 in that cycle:
    - Owner mN_ready=1 and err=1 for one cycle.
    - m_rdata=ERR_RDATA.
    - Next edge: mem_valid=0, state IDLE.
  - mem_ready=1 in the same cycle takes priority: normal completion, err=0.
- When undefined: no counter, err tied 0, wait is unbounded.

Decomposition:
- Package mem_bus_arb_pkg holds:
  - state_t enum {IDLE, BUSY}.
  - grant_t (2-bit one-hot) and constants GRANT_NONE, GRANT_M0, GRANT_M1.
  - Struct mem_req_t {instr, addr, wdata, wstrb}.
- One sub-module, mem_bus_rr_pick: combinational two-way round-robin picker. Inputs: valid[1:0], last. Outputs: one-hot winner, any.

Test Plan:
- Single m0 read addr=0x100, mem_ready after 2 wait cycles with rdata=0xDEADBEEF:
  - mem_valid rises 1 cycle after m0_valid.
  - m0_ready pulses once with m_rdata=0xDEADBEEF; m1_ready stays 0.
- m0 and m1 both valid from reset, zero-wait memory:
  - Grant order m0, m1, m0, m1 over 4 transactions.
  - grant matches the mem_addr source each time.
- m1 write addr=0x200, wstrb=0xF, wdata=0x12345678; m1 changes addr to 0x300 while BUSY:
  - mem_addr stays 0x200 until mem_ready.
  - mem_wstrb=0xF throughout.
- Reset asserted during BUSY:
  - mem_valid=0 and grant=00 immediately.
  - No mN_ready pulse.
  - After release, m0 wins a tie.
- With MEM_BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0:
  - m0_ready=1 and err=1 on the 5th BUSY cycle, with m_rdata=ERR_RDATA.
  - mem_valid=0 on the next cycle.
- With MEM_BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready=1 exactly on the timeout cycle:
  - Normal completion, err=0, m_rdata=mem_rdata.
